// File: rtl/axi_stream_window_ctrl.sv
// -----------------------------------------------------------------------------
// axi_stream_window_ctrl
//
// Control path for a 3x3 sliding-window filter on an AXI4-Stream video input.
// It tracks the row/column position of every pixel and forwards pixels to the
// external window datapath as a registered shift strobe. When a pixel completes
// a full 3x3 neighbourhood, it raises a window-valid handshake on the output
// side. It also checks tlast against the configured line length and raises a
// sticky error on a protocol violation.
//
// Ports
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   width_m1_i          pixels per row minus 1, latched on SOF
//   height_m1_i         rows per frame minus 1, latched on SOF
//   s_t*_i / s_tready_o AXI-Stream pixel input (tuser = SOF, tlast = EOL)
//   pix_o, pix_valid_o  pixel + shift strobe to the window datapath
//   line_len_o          latched width_m1 for the datapath line buffers
//   m_t*_o / m_tready_i window-result handshake (tuser = first, tlast = EOL)
//   frame_done_o        pulses when the last window of a frame is taken
//   err_o               sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module axi_stream_window_ctrl #(
    parameter int DW_G = 8,
    parameter int CW_G = 13
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [CW_G-1:0] width_m1_i,
    input  logic [CW_G-1:0] height_m1_i,
    input  logic [DW_G-1:0] s_tdata_i,
    input  logic            s_tvalid_i,
    input  logic            s_tuser_i,
    input  logic            s_tlast_i,
    output logic            s_tready_o,
    output logic [DW_G-1:0] pix_o,
    output logic            pix_valid_o,
    output logic [CW_G-1:0] line_len_o,
    output logic            m_tvalid_o,
    input  logic            m_tready_i,
    output logic            m_tuser_o,
    output logic            m_tlast_o,
    output logic            frame_done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [CW_G-1:0] TWO = CW_G'(2);
    localparam logic [CW_G-1:0] ONE = CW_G'(1);

    state_t          state_q, state_d;
    logic [CW_G-1:0] col_q, col_d, row_q, row_d;
    logic [CW_G-1:0] wm1_q, wm1_d, hm1_q, hm1_d;
    logic [DW_G-1:0] pix_q, pix_d;
    logic            pix_valid_q, pix_valid_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tuser_q, m_tuser_d;
    logic            m_tlast_q, m_tlast_d;
    logic            m_eof_q, m_eof_d;   // pending window is the last of its frame
    logic            err_q, err_d;

    logic            accept, sof, fwd, win, col_end, frame_end, tlast_bad, first_win;
    logic [CW_G-1:0] cur_col, cur_row, cur_w, cur_h;

    assign s_tready_o = !m_tvalid_q || m_tready_i;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        wm1_d       = wm1_q;
        hm1_d       = hm1_q;
        pix_d       = pix_q;
        pix_valid_d = 1'b0;
        m_tvalid_d  = m_tvalid_q;
        m_tuser_d   = m_tuser_q;
        m_tlast_d   = m_tlast_q;
        m_eof_d     = m_eof_q;
        err_d       = err_q;

        accept = s_tvalid_i && s_tready_o;
        sof    = accept && s_tuser_i;
        fwd    = accept && (s_tuser_i || state_q != IDLE);

        // An SOF pixel sits at (0,0) of the newly configured frame, so it is
        // checked against the incoming config rather than the latched one.
        cur_col = sof ? '0          : col_q;
        cur_row = sof ? '0          : row_q;
        cur_w   = sof ? width_m1_i  : wm1_q;
        cur_h   = sof ? height_m1_i : hm1_q;

        col_end   = (cur_col == cur_w);
        frame_end = col_end && (cur_row == cur_h);
        tlast_bad = (s_tlast_i != col_end);
        first_win = (cur_row == TWO) && (cur_col == TWO);
        // Rows/cols >= 2 imply width/height >= 2, so tiny frames never window.
        win       = fwd && !tlast_bad && (cur_row >= TWO) && (cur_col >= TWO);

        if (sof) begin
            wm1_d   = width_m1_i;
            hm1_d   = height_m1_i;
            state_d = PRIME;
            if (state_q != IDLE) err_d = 1'b1;
        end

        if (fwd) begin
            pix_d       = s_tdata_i;
            pix_valid_d = 1'b1;
            if (tlast_bad) begin
                // Lost line sync: drop back and wait for the next SOF.
                err_d   = 1'b1;
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end else begin
                if (col_end) begin
                    col_d = '0;
                    row_d = cur_row + ONE;
                end else begin
                    col_d = cur_col + ONE;
                    row_d = cur_row;
                end
                if (frame_end) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (first_win) begin
                    state_d = RUN;
                end
            end
        end

        // Hold the window result while downstream stalls; no pixel can be
        // accepted in that case because s_tready_o is low.
        if (!(m_tvalid_q && !m_tready_i)) begin
            m_tvalid_d = win;
            m_tuser_d  = win && first_win;
            m_tlast_d  = win && col_end;
            m_eof_d    = win && frame_end;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            wm1_q       <= '0;
            hm1_q       <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_eof_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            wm1_q       <= wm1_d;
            hm1_q       <= hm1_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tuser_q   <= m_tuser_d;
            m_tlast_q   <= m_tlast_d;
            m_eof_q     <= m_eof_d;
            err_q       <= err_d;
        end
    end

    assign pix_o        = pix_q;
    assign pix_valid_o  = pix_valid_q;
    assign line_len_o   = wm1_q;
    assign m_tvalid_o   = m_tvalid_q;
    assign m_tuser_o    = m_tuser_q;
    assign m_tlast_o    = m_tlast_q;
    assign frame_done_o = m_tvalid_q && m_tready_i && m_eof_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_axi_stream_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_window_ctrl
//
// Directed bench for axi_stream_window_ctrl: 4x4 frames with per-pixel
// expectations, a downstream stall, junk before SOF, a tlast error, reset
// mid-frame and a 2x2 frame that must not produce windows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_stream_window_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [12:0] width_m1_i, height_m1_i;
    logic [7:0]  s_tdata_i;
    logic        s_tvalid_i, s_tuser_i, s_tlast_i, s_tready_o;
    logic [7:0]  pix_o;
    logic        pix_valid_o;
    logic [12:0] line_len_o;
    logic        m_tvalid_o, m_tready_i, m_tuser_o, m_tlast_o;
    logic        frame_done_o, err_o;

    int checks = 0;
    int errors = 0;

    // negedge monitor: inputs only change 1 ns after a rising edge
    int          pix_cnt = 0, win_cnt = 0, fd_cnt = 0, pix_sum = 0;
    logic [15:0] wflags = '0;
    bit          junk_seen = 1'b0;

    int s_pix, s_win, s_fd, s_sum;

    axi_stream_window_ctrl #(.DW_G(8), .CW_G(13)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .width_m1_i(width_m1_i), .height_m1_i(height_m1_i),
        .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tuser_i(s_tuser_i),
        .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
        .pix_o(pix_o), .pix_valid_o(pix_valid_o), .line_len_o(line_len_o),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
        .frame_done_o(frame_done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (pix_valid_o) begin
            pix_cnt++;
            pix_sum += int'(pix_o);
            if (pix_o == 8'hAA || pix_o == 8'hBB) junk_seen = 1'b1;
        end
        if (m_tvalid_o && m_tready_i) begin
            win_cnt++;
            wflags = {wflags[13:0], m_tuser_o, m_tlast_o};
        end
        if (frame_done_o) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel at posedge+1 and return 1 ns after the edge that took it.
    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int n;
        n = 0;
        s_tdata_i = d; s_tuser_i = u; s_tlast_i = l; s_tvalid_i = 1'b1;
        @(negedge clk_i);
        while (!s_tready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=%0d expected=<50", n);
        end
        @(posedge clk_i);
        #1;
        s_tvalid_i = 1'b0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
    endtask

    task automatic snap();
        s_pix = pix_cnt; s_win = win_cnt; s_fd = fd_cnt; s_sum = pix_sum;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pix_o"},  pix_o, 0);
        chk({tag, "_pixv"},   pix_valid_o, 0);
        chk({tag, "_linelen"}, line_len_o, 0);
        chk({tag, "_mvalid"}, m_tvalid_o, 0);
        chk({tag, "_muser"},  m_tuser_o, 0);
        chk({tag, "_mlast"},  m_tlast_o, 0);
        chk({tag, "_fdone"},  frame_done_o, 0);
        chk({tag, "_err"},    err_o, 0);
    endtask

    // 4x4 frame, pixel k carries base+k. err_at: pixel given a wrong tlast
    // (0 = none). stall: hold m_tready_i low 5 cycles at the first window.
    task automatic run_frame(input logic [7:0] base, input int err_at, input int stall, input int npix);
        for (int k = 1; k <= npix; k++) begin
            int   r, c;
            logic fw, w;
            r  = (k - 1) / 4;
            c  = (k - 1) % 4;
            fw = (err_at == 0) || (k <= err_at);
            w  = fw && (k != err_at) && r >= 2 && c >= 2;
            send(base + 8'(k), k == 1, (c == 3) ^ (k == err_at));
            if (k == 1) begin
                width_m1_i = 13'd9; height_m1_i = 13'd9;
            end
            chk("pix_valid", pix_valid_o, fw);
            if (fw) chk("pix_o", pix_o, base + 8'(k));
            chk("m_tvalid", m_tvalid_o, w);
            chk("m_tuser", m_tuser_o, w && k == 11);
            chk("m_tlast", m_tlast_o, w && c == 3);
            if (k == 16) chk("frame_done", frame_done_o, err_at == 0);
            if (err_at != 0 && k >= err_at) chk("err_sticky", err_o, 1);
            if (stall != 0 && k == 11) begin
                m_tready_i = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    chk("stall_tready", s_tready_o, 0);
                    chk("stall_mvalid", m_tvalid_o, 1);
                    chk("stall_muser", m_tuser_o, 1);
                    chk("stall_mlast", m_tlast_o, 0);
                    if (i > 0) chk("stall_pixv", pix_valid_o, 0);
                end
                @(posedge clk_i);
                #1;
                m_tready_i = 1'b1;
            end
        end
        chk("line_len_held", line_len_o, 3);
        width_m1_i = 13'd3; height_m1_i = 13'd3;
    endtask

    initial begin
        rst_n_i = 1'b0; m_tready_i = 1'b1;
        width_m1_i = 13'd3; height_m1_i = 13'd3;
        s_tdata_i = '0; s_tvalid_i = 1'b0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
        #1;
        chk_zero_outputs("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // basic 4x4 frame
        snap();
        run_frame(8'h00, 0, 0, 16);
        settle();
        chk("f1_pix_cnt", pix_cnt - s_pix, 16);
        chk("f1_win_cnt", win_cnt - s_win, 4);
        chk("f1_fd_cnt", fd_cnt - s_fd, 1);
        chk("f1_wflags", wflags[7:0], 8'h91);
        chk("f1_pix_sum", pix_sum - s_sum, 136);
        chk("f1_err", err_o, 0);

        // downstream stall at the first window
        snap();
        run_frame(8'h40, 0, 1, 16);
        settle();
        chk("f2_pix_cnt", pix_cnt - s_pix, 16);
        chk("f2_win_cnt", win_cnt - s_win, 4);
        chk("f2_fd_cnt", fd_cnt - s_fd, 1);
        chk("f2_wflags", wflags[7:0], 8'h91);
        chk("f2_pix_sum", pix_sum - s_sum, 1160);

        // junk before SOF is dropped
        snap();
        send(8'hAA, 1'b0, 1'b0);
        chk("junk1_pixv", pix_valid_o, 0);
        send(8'hBB, 1'b0, 1'b1);
        chk("junk2_pixv", pix_valid_o, 0);
        run_frame(8'h20, 0, 0, 16);
        settle();
        chk("f3_junk", junk_seen, 0);
        chk("f3_pix_cnt", pix_cnt - s_pix, 16);
        chk("f3_win_cnt", win_cnt - s_win, 4);
        chk("f3_fd_cnt", fd_cnt - s_fd, 1);

        // tlast on pixel 3: error, resync on next SOF
        snap();
        run_frame(8'h60, 3, 0, 16);
        settle();
        chk("f4_pix_cnt", pix_cnt - s_pix, 3);
        chk("f4_win_cnt", win_cnt - s_win, 0);
        chk("f4_fd_cnt", fd_cnt - s_fd, 0);
        snap();
        run_frame(8'h00, 0, 0, 16);
        settle();
        chk("f5_win_cnt", win_cnt - s_win, 4);
        chk("f5_err_sticky", err_o, 1);

        // reset after pixel 9
        run_frame(8'h80, 0, 0, 9);
        #2 rst_n_i = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        send(8'h55, 1'b0, 1'b0);
        chk("post_rst_drop", pix_valid_o, 0);
        snap();
        run_frame(8'h10, 0, 0, 16);
        settle();
        chk("f6_pix_cnt", pix_cnt - s_pix, 16);
        chk("f6_win_cnt", win_cnt - s_win, 4);
        chk("f6_fd_cnt", fd_cnt - s_fd, 1);

        // 2x2 frame: forwarded, no windows, back to IDLE
        width_m1_i = 13'd1; height_m1_i = 13'd1;
        snap();
        for (int k = 1; k <= 4; k++) begin
            send(8'(k + 8'h30), k == 1, (k % 2) == 0);
            chk("small_pixv", pix_valid_o, 1);
            chk("small_mvalid", m_tvalid_o, 0);
        end
        settle();
        chk("small_pix_cnt", pix_cnt - s_pix, 4);
        chk("small_win_cnt", win_cnt - s_win, 0);
        chk("small_fd_cnt", fd_cnt - s_fd, 0);
        chk("small_linelen", line_len_o, 1);
        send(8'h77, 1'b0, 1'b0);
        chk("small_idle_drop", pix_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
